// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding and grant-index sizing.
package wb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Width needed to index n masters; never below one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Rotating priority encoder: first set request strictly after 'last', wrapping.
module rr_pick
  import wb_pkg::*;
#(
  parameter int NMASTERS = 2,
  localparam int GW = grant_width(NMASTERS)
) (
  input  logic [NMASTERS-1:0] req,
  input  logic [GW-1:0]       last,
  output logic                valid,
  output logic [GW-1:0]       idx
);

  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      c = (int'(last) + i) % NMASTERS;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: NMASTERS pipelined Wishbone masters onto one slave port,
// with a per-tenure cap on accepted-but-unacknowledged strobes.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int MAXOUT   = 4,
  localparam int SELW    = DWIDTH / 8,
  localparam int GW      = grant_width(NMASTERS),
  localparam int CW      = $clog2(MAXOUT + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NMASTERS-1:0]        m_cyc_i,
  input  logic [NMASTERS-1:0]        m_stb_i,
  input  logic [NMASTERS-1:0]        m_we_i,
  input  logic [NMASTERS*AWIDTH-1:0] m_adr_i,
  input  logic [NMASTERS*DWIDTH-1:0] m_dat_i,
  input  logic [NMASTERS*SELW-1:0]   m_sel_i,
  output logic [NMASTERS-1:0]        m_ack_o,
  output logic [NMASTERS-1:0]        m_stall_o,
  output logic [DWIDTH-1:0]          m_dat_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [AWIDTH-1:0]          s_adr_o,
  output logic [DWIDTH-1:0]          s_dat_o,
  output logic [SELW-1:0]            s_sel_o,
  input  logic                       s_ack_i,
  input  logic                       s_stall_i,
  input  logic [DWIDTH-1:0]          s_dat_i,
  output logic [GW-1:0]              grant_o
);

  state_t        state;
  logic [GW-1:0] g;
  logic [GW-1:0] last;
  logic [CW-1:0] cnt;
  logic [GW-1:0] pick_idx;
  logic          pick_valid;
  logic          granted;
  logic          owner_cyc;
  logic          cap_hit;
  logic          accept;
  logic          ack_counted;

  rr_pick #(.NMASTERS(NMASTERS)) u_pick (
    .req   (m_cyc_i),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign granted     = (state == ST_GRANT);
  assign owner_cyc   = m_cyc_i[g];
  assign cap_hit     = (cnt == CW'(MAXOUT));
  assign s_cyc_o     = granted & owner_cyc;
  assign s_stb_o     = s_cyc_o & m_stb_i[g] & ~cap_hit;
  assign s_we_o      = m_we_i[g];
  assign s_adr_o     = m_adr_i[g*AWIDTH +: AWIDTH];
  assign s_dat_o     = m_dat_i[g*DWIDTH +: DWIDTH];
  assign s_sel_o     = m_sel_i[g*SELW +: SELW];
  assign m_dat_o     = s_dat_i;
  assign grant_o     = g;
  assign accept      = s_stb_o & ~s_stall_i;
  // Acks arriving with nothing outstanding (e.g. after an abort) are dropped.
  assign ack_counted = granted & s_ack_i & (cnt != '0);

  always_comb begin
    m_stall_o = '1;
    m_ack_o   = '0;
    if (granted) begin
      m_stall_o[g] = s_stall_i | cap_hit;
      m_ack_o[g]   = ack_counted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      g     <= '0;
      last  <= GW'(NMASTERS - 1);
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state <= ST_GRANT;
            g     <= pick_idx;
            last  <= pick_idx;
            cnt   <= '0;
          end
        end
        ST_GRANT: begin
          // Owner dropping cyc ends the tenure, aborting anything outstanding.
          if (!owner_cyc) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (accept && !ack_counted) begin
            cnt <= cnt + CW'(1);
          end else if (ack_counted && !accept) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Round-robin arbiter connecting NMASTERS pipelined Wishbone masters to one pipelined Wishbone slave port. Generalises our bus definition in master count, data width (byte-select width derived, not fixed at 4) and adds outstanding-transaction tracking with a configurable cap. Sits between CPU/DMA/video masters and the shared memory/interconnect slave.

## Interface
Parameters:
- NMASTERS, 2, number of master ports (≥2)
- AWIDTH, 32, address width
- DWIDTH, 32, data width (multiple of 8)
- SELW, DWIDTH/8, byte-select width (derived, not overridden)
- MAXOUT, 4, max accepted-but-unacked strobes per tenure (≥1)

Ports (master-side vectors flattened, master i at slice i):
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_cyc_i  in  NMASTERS  cycle request
- m_stb_i  in  NMASTERS  strobe
- m_we_i  in  NMASTERS  write enable
- m_adr_i  in  NMASTERS*AWIDTH  addresses
- m_dat_i  in  NMASTERS*DWIDTH  write data
- m_sel_i  in  NMASTERS*SELW  byte selects
- m_ack_o  out  NMASTERS  ack, routed to granted master only
- m_stall_o  out  NMASTERS  stall
- m_dat_o  out  DWIDTH  read data, broadcast (= s_dat_i)
- s_cyc_o, s_stb_o, s_we_o  out  1  slave controls
- s_adr_o  out  AWIDTH; s_dat_o  out  DWIDTH; s_sel_o  out  SELW
- s_ack_i, s_stall_i  in  1; s_dat_i  in  DWIDTH
- grant_o  out  clog2(NMASTERS)  current owner (debug)

## Operation
- States: IDLE, GRANT. Registers: state, grant index g, last-grant pointer, outstanding counter cnt (width clog2(MAXOUT+1)).
- IDLE: if any m_cyc_i set, pick first requester searching from (last+1) mod NMASTERS upward with wrap; register g, last←g, go GRANT. Else stay.
- GRANT: s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & (cnt<MAXOUT); s_we/adr/dat/sel = master g slices.
- m_stall_o[g] = s_stall_i | (cnt==MAXOUT); all other m_stall_o = 1. In IDLE all m_stall_o = 1.
- m_ack_o[g] = s_ack_i & (cnt≠0); others 0. Ack with cnt==0 is dropped.
- Accept = s_stb_o & ~s_stall_i. cnt: +1 on accept only, −1 on counted ack only, unchanged on both or neither.
- Release: m_cyc_i[g] low in GRANT → s_cyc_o low same cycle, cnt←0, state←IDLE next cycle. Release with cnt>0 is an abort; late acks ignored (cnt==0).
- Master holds grant as long as cyc stays high (bus lock); no preemption.

## Timing
- Reset (rst_i high at clock edge): state IDLE, g=0, last=NMASTERS−1 (master 0 wins first), cnt=0; s_cyc_o=s_stb_o=0, m_ack_o=0, m_stall_o all 1, grant_o=0. Reset mid-tenure drops s_cyc_o next cycle regardless of cnt.
- Arbitration latency: request seen in IDLE cycle t → s_cyc_o high cycle t+1; first strobe can be accepted at t+1.
- Slave-side controls and m_ack_o/m_stall_o are combinational from registered g/cnt; no added data latency.
- One IDLE cycle between tenures (release at t, next grant visible t+2).
- Simultaneous requests: rotation order only; masters not granted see stall=1 and ack=0 until granted.

## Structure
- Package wb_pkg: state enum (IDLE, GRANT), helper function for grant-index width; shared with future interconnect blocks.
- Sub-module rr_pick: combinational rotating priority encoder (req vector, last pointer → valid, index), parametrised by NMASTERS.
- Top holds FSM, counter, muxing; target 150–250 lines.

## Test plan
- Reset: assert rst_i 2 cycles with m_cyc_i=2'b11 → s_cyc_o=0, m_stall_o=2'b11; after release master 0 granted first, s_cyc_o high one cycle later.
- Fairness (NMASTERS=3, all requesting, each single-beat tenure): grant_o sequence 0,1,2,0,1,2.
- Pipelining: master 1 issues 4 strobes back-to-back, slave acks at 3-cycle latency → 4 acks to m_ack_o[1] only, cnt returns 0, no stalls (MAXOUT=4).
- Cap: MAXOUT=2, slave never acks → third strobe sees m_stall_o[g]=1 and s_stb_o=0; one ack → cnt 2→1, third strobe accepted next cycle.
- Simultaneous accept+ack at cnt=1 → cnt stays 1; slave stall held 3 cycles → master stalled, address stable on s_adr_o.
- Abort: master drops cyc at cnt=2 → s_cyc_o low same cycle, IDLE next; two late s_ack_i pulses produce no m_ack_o; other master granted afterwards.
